// File: rtl/pc_unit_if.sv
// Bus between the control FSM and the program-counter unit: next-PC controls
// from the FSM and the PC/EPC/RAS status returned by the unit.
interface pc_unit_if #(
  parameter int WIDTH = 32
);
  logic             pc_write;
  logic [1:0]       sel;
  logic             link;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] target;
  logic             exc;
  logic             eret;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] epc;
  logic             misalign;
  logic             ras_empty;
  logic             ras_full;

  modport master (
    output pc_write, sel, link, imm, target, exc, eret,
    input  pc, pc_plus4, epc, misalign, ras_empty, ras_full
  );

  modport slave (
    input  pc_write, sel, link, imm, target, exc, eret,
    output pc, pc_plus4, epc, misalign, ras_empty, ras_full
  );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit: seq/branch/jump/return next-PC, exception entry/return
// via EPC, and an optional return-address stack enabled by the PC_RAS_EN macro.
module pc_unit #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(32'h0000_0180),
  parameter int               RAS_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  pc_unit_if.slave bus
);

  localparam logic [1:0] SEL_SEQ = 2'd0;
  localparam logic [1:0] SEL_BR  = 2'd1;
  localparam logic [1:0] SEL_JMP = 2'd2;
  localparam logic [1:0] SEL_RET = 2'd3;

  logic [WIDTH-1:0] pc_reg, pc_next;
  logic [WIDTH-1:0] epc_reg, epc_next;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] br_target;
  logic [WIDTH-1:0] ret_target;
  logic             commit;

  assign pc_plus4  = pc_reg + WIDTH'(4);
  assign br_target = pc_plus4 + {bus.imm[WIDTH-3:0], 2'b00};
  // Only a plain pc_write cycle (no exception traffic) may touch the RAS.
  assign commit    = bus.pc_write & ~bus.exc & ~bus.eret;

  logic [1:0] unused_imm_hi;
  assign unused_imm_hi = bus.imm[WIDTH-1:WIDTH-2];

`ifdef PC_RAS_EN
  localparam int          AW        = $clog2(RAS_DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(RAS_DEPTH);
  localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] IDX_ONE = AW'(1);

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [AW-1:0]    top_reg, top_next;
  logic [AW:0]      cnt_reg, cnt_next;
  logic [AW-1:0]    wr_idx;
  logic             wr_en;
  logic             ras_has_entry;

  assign ras_has_entry = (cnt_reg != '0);
  assign ret_target    = ras_has_entry ? ras_mem[top_reg] : bus.target;

  always_comb begin
    top_next = top_reg;
    cnt_next = cnt_reg;
    wr_en    = 1'b0;
    wr_idx   = top_reg;
    if (commit) begin
      if (bus.sel == SEL_RET) begin
        if (bus.link) begin
          // Return-and-call: the popped slot is reused for the new link.
          wr_en = 1'b1;
          if (!ras_has_entry) begin
            cnt_next = CNT_ONE;
          end
        end else if (ras_has_entry) begin
          top_next = top_reg - IDX_ONE;
          cnt_next = cnt_reg - CNT_ONE;
        end
      end else if (bus.link) begin
        wr_en    = 1'b1;
        wr_idx   = top_reg + IDX_ONE;
        top_next = top_reg + IDX_ONE;
        // A full stack wraps onto its oldest entry without growing.
        if (cnt_reg != DEPTH_CNT) begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top_reg <= '0;
      cnt_reg <= '0;
    end else begin
      top_reg <= top_next;
      cnt_reg <= cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      ras_mem[wr_idx] <= pc_plus4;
    end
  end

  assign bus.ras_empty = (cnt_reg == '0);
  assign bus.ras_full  = (cnt_reg == DEPTH_CNT);
`else
  localparam int unused_ras_depth = RAS_DEPTH;
  logic unused_link;

  assign unused_link   = bus.link;
  assign ret_target    = bus.target;
  assign bus.ras_empty = 1'b1;
  assign bus.ras_full  = 1'b0;
`endif

  always_comb begin
    pc_next  = pc_reg;
    epc_next = epc_reg;
    if (bus.exc) begin
      epc_next = pc_reg;
      pc_next  = EXC_VEC;
    end else if (bus.eret) begin
      pc_next = epc_reg;
    end else if (bus.pc_write) begin
      case (bus.sel)
        SEL_SEQ: pc_next = pc_plus4;
        SEL_BR:  pc_next = br_target;
        SEL_JMP: pc_next = bus.target;
        SEL_RET: pc_next = ret_target;
        default: pc_next = pc_plus4;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg  <= RESET_VEC;
      epc_reg <= '0;
    end else begin
      pc_reg  <= pc_next;
      epc_reg <= epc_next;
    end
  end

  assign bus.pc       = pc_reg;
  assign bus.pc_plus4 = pc_plus4;
  assign bus.epc      = epc_reg;
  assign bus.misalign = (pc_reg[1:0] != 2'b00);

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus random traffic
// compared against a queue-based behavioural model of PC, EPC and RAS.
module tb_pc_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] EXCV  = 32'h0000_0180;

  logic clk;
  logic rst;

  pc_unit_if #(.WIDTH(32)) bus ();

  pc_unit #(
    .WIDTH    (32),
    .RESET_VEC(32'h0),
    .EXC_VEC  (EXCV),
    .RAS_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int txn    = 0;

  logic [31:0] m_pc;
  logic [31:0] m_epc;
  logic [31:0] m_ras[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic ras_on();
`ifdef PC_RAS_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_all(input string tag);
    logic exp_empty, exp_full;
    exp_empty = ras_on() ? (m_ras.size() == 0) : 1'b1;
    exp_full  = ras_on() ? (m_ras.size() == DEPTH) : 1'b0;
    check({tag, ".pc"},    bus.pc, m_pc);
    check({tag, ".pc4"},   bus.pc_plus4, m_pc + 32'd4);
    check({tag, ".epc"},   bus.epc, m_epc);
    check({tag, ".mis"},   {31'd0, bus.misalign}, {31'd0, m_pc[1:0] != 2'b00});
    check({tag, ".empty"}, {31'd0, bus.ras_empty}, {31'd0, exp_empty});
    check({tag, ".full"},  {31'd0, bus.ras_full}, {31'd0, exp_full});
  endtask

  // Reference: next PC from the priority rules, RAS as a bounded queue (back = top).
  task automatic model(input bit w, input logic [1:0] s, input bit l,
                       input logic [31:0] im, input logic [31:0] tg,
                       input bit e, input bit er);
    logic [31:0] seq;
    seq = m_pc + 32'd4;
    if (e) begin
      m_epc = m_pc;
      m_pc  = EXCV;
    end else if (er) begin
      m_pc = m_epc;
    end else if (w) begin
      if (s == 2'd0) m_pc = seq;
      else if (s == 2'd1) m_pc = seq + im * 32'd4;
      else if (s == 2'd2 || !ras_on()) begin
        m_pc = tg;
        if (ras_on() && l) begin
          m_ras.push_back(seq);
          if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end
      end else begin
        m_pc = (m_ras.size() != 0) ? m_ras[m_ras.size()-1] : tg;
        if (l) begin
          if (m_ras.size() == 0) m_ras.push_back(seq);
          else m_ras[m_ras.size()-1] = seq;
        end else if (m_ras.size() != 0) begin
          void'(m_ras.pop_back());
        end
      end
      if (s == 2'd0 || s == 2'd1) begin
        if (ras_on() && l) begin
          m_ras.push_back(seq);
          if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end
      end
    end
  endtask

  task automatic step(input string tag, input bit w, input logic [1:0] s, input bit l,
                      input logic [31:0] im, input logic [31:0] tg,
                      input bit e, input bit er);
    @(negedge clk);
    bus.pc_write = w;
    bus.sel      = s;
    bus.link     = l;
    bus.imm      = im;
    bus.target   = tg;
    bus.exc      = e;
    bus.eret     = er;
    model(w, s, l, im, tg, e, er);
    @(posedge clk);
    #1;
    txn++;
    $display("txn %0d %s: w=%0b sel=%0d link=%0b exc=%0b eret=%0b -> pc=%h epc=%h",
             txn, tag, w, s, l, e, er, bus.pc, bus.epc);
    check_all(tag);
  endtask

  task automatic model_reset();
    m_pc  = 32'h0;
    m_epc = 32'h0;
    m_ras.delete();
  endtask

  initial begin
    rst          = 1'b1;
    bus.pc_write = 1'b0;
    bus.sel      = 2'd0;
    bus.link     = 1'b0;
    bus.imm      = '0;
    bus.target   = '0;
    bus.exc      = 1'b0;
    bus.eret     = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Sequential then hold
    step("seq1", 1, 2'd0, 0, 0, 0, 0, 0);
    step("seq2", 1, 2'd0, 0, 0, 0, 0, 0);
    step("seq3", 1, 2'd0, 0, 0, 0, 0, 0);
    step("hold", 0, 2'd0, 0, 0, 0, 0, 0);

    // Branch backwards, jump, misaligned jump
    step("j100", 1, 2'd2, 0, 0, 32'h100, 0, 0);
    step("br",   1, 2'd1, 0, 32'hFFFF_FFFE, 0, 0, 0);
    step("j2000", 1, 2'd2, 0, 0, 32'h2000, 0, 0);
    step("jmis", 1, 2'd2, 0, 0, 32'h2002, 0, 0);

    // Exception beats pc_write, then eret
    step("j40",  1, 2'd2, 0, 0, 32'h40, 0, 0);
    step("exc",  1, 2'd2, 1, 0, 32'h999C, 1, 0);
    step("eret", 1, 2'd2, 1, 0, 32'h777C, 0, 1);

    // Nested calls and returns, then return on empty stack
    step("j10",   1, 2'd2, 0, 0, 32'h10, 0, 0);
    step("call1", 1, 2'd2, 1, 0, 32'h20, 0, 0);
    step("call2", 1, 2'd2, 1, 0, 32'h30, 0, 0);
    step("call3", 1, 2'd2, 1, 0, 32'h1000, 0, 0);
    step("ret1",  1, 2'd3, 0, 0, 32'hAAA0, 0, 0);
    step("ret2",  1, 2'd3, 0, 0, 32'hBBB0, 0, 0);
    step("ret3",  1, 2'd3, 0, 0, 32'hCCC0, 0, 0);
    step("ret4",  1, 2'd3, 0, 0, 32'h500, 0, 0);

    // Overflow: five pushes into a four-deep stack, four pops
    step("j0", 1, 2'd2, 0, 0, 32'h0, 0, 0);
    for (int i = 0; i < 5; i++) step("push", 1, 2'd0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("pop", 1, 2'd3, 0, 0, 32'h4440, 0, 0);

    // Return-and-link on empty and non-empty stack
    step("rl_empty", 1, 2'd3, 1, 0, 32'h300, 0, 0);
    step("rl_full",  1, 2'd3, 1, 0, 32'h600, 0, 0);

    // Asynchronous reset mid-cycle
    @(negedge clk);
    bus.pc_write = 1'b0;
    bus.exc      = 1'b0;
    bus.eret     = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] r_imm, r_tgt;
      bit r_exc, r_eret, r_w, r_l;
      logic [1:0] r_sel;
      r_exc  = ($urandom_range(0, 15) == 0);
      r_eret = ($urandom_range(0, 15) == 0);
      r_w    = ($urandom_range(0, 3) != 0);
      r_l    = $urandom_range(0, 1) == 1;
      r_sel  = 2'($urandom_range(0, 3));
      r_imm  = 32'($urandom_range(0, 63)) - 32'd32;
      r_tgt  = $urandom;
      if ($urandom_range(0, 7) != 0) r_tgt[1:0] = 2'b00;
      step("rand", r_w, r_sel, r_l, r_imm, r_tgt, r_exc, r_eret);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the multicycle CPU. It holds the PC and computes the next PC from one of four sources: sequential, branch, jump, or return. It also handles exception entry/return through an internal EPC register, and keeps an optional return-address stack (RAS). It sits between the control FSM (which drives `pc_write`/`sel`) and the instruction memory address port.

## Interface
Parameters:
- `WIDTH`, 32, PC/address width in bits (≥ 8).
- `RESET_VEC`, 0, PC value loaded on reset.
- `EXC_VEC`, 32'h0000_0180, PC value loaded on exception entry (truncated to `WIDTH`).
- `RAS_DEPTH`, 4, number of RAS entries (power of 2, ≥ 2).

Ports:
- `clk` input 1: clock; all state updates on rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `pc_write` input 1: commit next PC this cycle.
- `sel` input 2: next-PC source. 0 = seq, 1 = branch, 2 = jump, 3 = return.
- `link` input 1: with `pc_write`, push `pc_plus4` onto the RAS.
- `imm` input `WIDTH`: sign-extended word offset for a branch.
- `target` input `WIDTH`: absolute jump target; also the fallback for a return.
- `exc` input 1: exception request.
- `eret` input 1: exception return.
- `pc` output `WIDTH`: current PC (registered).
- `pc_plus4` output `WIDTH`: `pc + 4` (combinational).
- `epc` output `WIDTH`: saved exception PC (registered).
- `misalign` output 1: `pc[1:0] != 0` (combinational).
- `ras_empty` output 1: RAS count == 0.
- `ras_full` output 1: RAS count == `RAS_DEPTH`.

## Operation
- **Next-PC candidates.** All arithmetic is modulo 2^WIDTH; no overflow flag.
  - seq = `pc + 4`
  - branch = `pc + 4 + (imm << 2)`
  - jump = `target`
  - return = RAS top if non-empty, else `target`
- **Update priority per edge:** `exc` > `eret` > `pc_write` > hold.
  - `exc`: `epc <= pc`, `pc <= EXC_VEC`. `pc_write`, `sel`, `link` and `eret` are ignored; the RAS is untouched.
  - `eret` (no `exc`): `pc <= epc`; `epc` unchanged; RAS untouched.
  - `pc_write` only: `pc <=` the candidate selected by `sel`.
  - None asserted: all state holds.
- **RAS (circular buffer, top pointer + count).** The RAS only updates on a `pc_write` cycle without `exc`/`eret`.
  - Push (`link`=1, `sel`≠3): write `pc_plus4` at top+1, count+1. When full, the oldest entry is overwritten and count stays at `RAS_DEPTH`.
  - Pop (`sel`=3, `link`=0): non-empty → next PC = top, count−1. Empty → next PC = `target`, no pointer change.
  - Push+pop (`sel`=3, `link`=1): next PC = current top (or `target` if empty); the top entry is replaced by `pc_plus4`; count unchanged, or 0→1 if empty.
- `misalign` is reported only; the unit does not trap on it.

## Timing
- Reset values: `pc` = `RESET_VEC`, `epc` = 0, RAS count = 0 (`ras_empty` = 1, `ras_full` = 0). RAS entry contents are don't-care.
- `rst` asserted mid-operation clears state immediately, regardless of `clk`. The first update after release happens on the first rising edge with `rst` low.
- Latency is one cycle: inputs sampled at edge N appear on `pc`/`epc`/flags after edge N.
- `pc_plus4` and `misalign` follow `pc` combinationally.
- `ras_empty` and `ras_full` are derived from the registered count, so they are valid one cycle after a push or pop.

## Configuration
- `PC_RAS_EN` defined: RAS is built as described above.
- `PC_RAS_EN` undefined: no RAS storage.
  - `sel`=3 behaves exactly like `sel`=2 (jump to `target`).
  - `link` is ignored.
  - `ras_empty` is tied to 1 and `ras_full` to 0.
  - All other behaviour is identical.

## Test plan
- Reset/seq: assert `rst` mid-cycle → `pc`=0 immediately. Release, then 3 cycles of `pc_write`=1, `sel`=0 → `pc` = 4, 8, 12. Hold `pc_write`=0 → `pc` stays 12.
- Branch/jump: at `pc`=0x100, `sel`=1, `imm`=0xFFFF_FFFE → `pc`=0xFC. Then `sel`=2, `target`=0x2000 → `pc`=0x2000. With `target`=0x2002 → `misalign`=1.
- Exception priority: at `pc`=0x40, assert `exc`=1 with `pc_write`=1, `sel`=2 → `pc`=0x180, `epc`=0x40. Next cycle `eret`=1 → `pc`=0x40.
- RAS nesting (`PC_RAS_EN`): calls from 0x10, 0x20, 0x30 with `link`=1, then 3 returns → `pc` = 0x34, 0x24, 0x14, and `ras_empty`=1 afterwards. A 4th return with `target`=0x500 → `pc`=0x500.
- RAS overflow (`RAS_DEPTH`=4): 5 pushes of 0x4, 0x8, 0xC, 0x10, 0x14 → `ras_full`=1. 4 pops return 0x14, 0x10, 0xC, 0x8; 0x4 is lost.
- Macro off: `sel`=3, `link`=1, `target`=0x300 → `pc`=0x300, `ras_empty`=1 constant.
